// File: rtl/keypad_emulator.sv
// keypad_emulator: far-end 4x4 membrane keypad model; replays key-press commands onto active-low rows.
//   Optional contact bounce around each press when KEYPAD_EMU_BOUNCE_EN is defined.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     cmd_valid/cmd_ready     press command handshake (ready only when idle)
//     cmd_key, cmd_hold       key code 0..15 and contact duration in cycles (0 acts as 1)
//     column                  active-low column strobes from the scanner
//     row                     active-low row lines back to the scanner, 4'b1111 when open
//     busy, done              command in progress; one-cycle pulse at end of release gap
//     key_active              one-hot of the key whose contact is closed, else 0
module keypad_emulator #(
    parameter int HOLD_W      = 16,
    parameter int RELEASE_GAP = 256,
    parameter int BOUNCE_LEN  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        column,
    output logic [3:0]        row,
    output logic              busy,
    output logic              done,
    output logic [15:0]       key_active
);
    localparam int GAP_W = $clog2(RELEASE_GAP + 1);
    // Per key (nibble k): {column index, row index} in the matrix.
    localparam logic [63:0] KEY_POS = 64'h8401_2359_D6AE_7BFC;

    if (RELEASE_GAP < 1 || BOUNCE_LEN < 1) begin : g_param_check
        $error("keypad_emulator: RELEASE_GAP and BOUNCE_LEN must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, PRESS, GAP, BOUNCE_IN, BOUNCE_OUT} state_t;

    state_t            state, state_n;
    logic [3:0]        key, key_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic              contact, contact_n;
    logic [3:0]        pos;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int BW = $clog2(BOUNCE_LEN + 1);
    logic [BW-1:0]     bnc_cnt, bnc_n;
    logic [7:0]        lfsr, lfsr_n;

    // Fibonacci x^8+x^6+x^5+x^4+1, free-running every cycle.
    assign lfsr_n = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            key      <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            contact  <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            bnc_cnt  <= '0;
            lfsr     <= 8'hA5;
`endif
        end else begin
            state    <= state_n;
            key      <= key_n;
            hold_cnt <= hold_n;
            gap_cnt  <= gap_n;
            contact  <= contact_n;
`ifdef KEYPAD_EMU_BOUNCE_EN
            bnc_cnt  <= bnc_n;
            lfsr     <= lfsr_n;
`endif
        end
    end

    // contact_n is the contact state for the cycle after the edge, so the
    // registered contact lines up exactly with the state it belongs to.
    always_comb begin
        state_n   = state;
        key_n     = key;
        hold_n    = hold_cnt;
        gap_n     = gap_cnt;
        contact_n = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
        bnc_n     = bnc_cnt;
`endif
        case (state)
            IDLE: if (cmd_valid) begin
                key_n  = cmd_key;
                hold_n = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
`ifdef KEYPAD_EMU_BOUNCE_EN
                state_n   = BOUNCE_IN;
                bnc_n     = BW'(BOUNCE_LEN);
                contact_n = (BOUNCE_LEN == 1) | lfsr_n[0];
`else
                state_n   = PRESS;
                contact_n = 1'b1;
`endif
            end
            PRESS: if (hold_cnt == HOLD_W'(1)) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
                state_n   = BOUNCE_OUT;
                bnc_n     = BW'(BOUNCE_LEN);
                contact_n = (BOUNCE_LEN != 1) & lfsr_n[0];
`else
                state_n = GAP;
                gap_n   = GAP_W'(RELEASE_GAP);
`endif
            end else begin
                hold_n    = hold_cnt - 1'b1;
                contact_n = 1'b1;
            end
            GAP: if (gap_cnt == GAP_W'(1)) state_n = IDLE;
                 else gap_n = gap_cnt - 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            // Last cycle of each bounce window is forced to its settled value.
            BOUNCE_IN: if (bnc_cnt == BW'(1)) begin
                state_n   = PRESS;
                contact_n = 1'b1;
            end else begin
                bnc_n     = bnc_cnt - 1'b1;
                contact_n = (bnc_cnt == BW'(2)) | lfsr_n[0];
            end
            BOUNCE_OUT: if (bnc_cnt == BW'(1)) begin
                state_n = GAP;
                gap_n   = GAP_W'(RELEASE_GAP);
            end else begin
                bnc_n     = bnc_cnt - 1'b1;
                contact_n = (bnc_cnt != BW'(2)) & lfsr_n[0];
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = ~cmd_ready;
    assign done       = (state == GAP) && (gap_cnt == GAP_W'(1));
    assign key_active = contact ? (16'b1 << key) : 16'd0;
    assign pos        = KEY_POS[{key, 2'b00} +: 4];

    // Only one key can be closed, so a single pull-down covers wired-AND of several low columns.
    always_comb begin
        row = 4'b1111;
        if (contact && !column[pos[3:2]]) row[pos[1:0]] = 1'b0;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed bench for keypad_emulator with a cycle-window reference model.
module tb_keypad_emulator;
    localparam int G = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_key = '0;
    logic [15:0] cmd_hold = '0;
    logic [3:0]  column = 4'b0000;
    logic [3:0]  row;
    logic        busy, done;
    logic [15:0] key_active;

    int tests = 0;
    int fails = 0;

    keypad_emulator #(.HOLD_W(16), .RELEASE_GAP(G), .BOUNCE_LEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_key(cmd_key), .cmd_hold(cmd_hold), .column(column), .row(row),
        .busy(busy), .done(done), .key_active(key_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Key at [column][row], transcribed from the keypad wiring table.
    int kmap [4][4];
    initial kmap = '{'{13, 12, 11, 10}, '{14, 9, 6, 3}, '{15, 8, 5, 2}, '{0, 7, 4, 1}};

    // Model: an accepted command at edge acc closes contact for cycles
    // [acc, acc+H-1], then G open cycles with done on the last one.
    longint cyc = 0, m_acc = 0, m_hold = 0;
    bit     m_active = 0;
    int     m_key = 0;

    always @(posedge clk) begin
        bit idle_old;
        idle_old = !m_active || (cyc >= m_acc + m_hold + G);
        cyc++;
        if (!rst_n) m_active = 0;
        else if (idle_old && cmd_valid) begin
            m_active = 1;
            m_acc    = cyc;
            m_hold   = (cmd_hold == 0) ? 1 : cmd_hold;
            m_key    = cmd_key;
        end
    end

    always @(negedge clk) if (rst_n) begin
        bit e_contact, e_busy, e_done;
        logic [3:0] e_row;
        e_busy    = m_active && (cyc < m_acc + m_hold + G);
        e_contact = m_active && (cyc >= m_acc) && (cyc < m_acc + m_hold);
        e_done    = m_active && (cyc == m_acc + m_hold + G - 1);
        e_row     = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (e_contact && kmap[c][r] == m_key && !column[c]) e_row[r] = 1'b0;
        chk("row", row, e_row);
        chk("cmd_ready", cmd_ready, !e_busy);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("key_active", key_active, e_contact ? (longint'(1) << m_key) : 0);
    end

    task automatic send(input int k, input int h);
        int n;
        cmd_key = 4'(k);
        cmd_hold = 16'(h);
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", n < 2000, 1);
        @(posedge clk);
        #2 cmd_valid = 1'b0;
    endtask

    // Returns contact cycle count, done index (0 = accept cycle), and first-cycle outputs.
    task automatic measure(input int k, input int h, output int n_act, output int idx,
                           output logic [15:0] ka0, output logic [3:0] row0);
        send(k, h);
        n_act = 0;
        idx = -1;
        ka0 = '0;
        row0 = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                ka0 = key_active;
                row0 = row;
            end
            if (key_active != 0) n_act++;
            if (done) begin
                idx = i;
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_in_time", n < 3000, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n_act, idx, n;
        logic [15:0] ka0;
        logic [3:0]  row0;
        #1;
        chk("reset_row", row, 4'b1111);
        chk("reset_ready", cmd_ready, 1);
        chk("reset_key_active", key_active, 0);
        chk("reset_done", done, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Timing: key 5, hold 100 with column 2 strobed.
        column = 4'b1011;
        measure(5, 100, n_act, idx, ka0, row0);
        chk("t_key_active", ka0, 16'h0020);
        chk("t_row", row0, 4'b1011);
        chk("t_hold_len", n_act, 100);
        chk("t_done_idx", idx, 355);

        // Handshake: new command held valid during press is ignored until idle.
        column = 4'b1101;
        send(3, 50);
        cmd_key = 4'd9;
        cmd_hold = 16'd10;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("hs_done_seen", done, 1);
        @(negedge clk);
        chk("hs_idle_ready", cmd_ready, 1);
        chk("hs_idle_ka", key_active, 0);
        @(negedge clk);
        chk("hs_key9", key_active, 16'h0200);
        @(posedge clk);
        #2 cmd_valid = 1'b0;
        wait_idle();

        // Map sweep: each key, each single-low column.
        for (int k = 0; k < 16; k++) begin
            column = 4'b1111;
            send(k, 20);
            for (int c = 0; c < 4; c++) begin
                column = ~(4'b0001 << c);
                @(negedge clk);
                if (k == 0 && c == 3) chk("map_key0_col3", row, 4'b1110);
                @(posedge clk);
                #2;
            end
            column = 4'b1111;
            wait_idle();
        end

        // Edge: hold 0 gives one contact cycle.
        column = 4'b0000;
        measure(12, 0, n_act, idx, ka0, row0);
        chk("h0_len", n_act, 1);
        chk("h0_row", row0, 4'b1101);
        chk("h0_done_idx", idx, 256);

        // Edge: no column strobed, rows stay open, done still pulses.
        column = 4'b1111;
        measure(6, 30, n_act, idx, ka0, row0);
        chk("nocol_len", n_act, 30);
        chk("nocol_row", row0, 4'b1111);
        chk("nocol_done_idx", idx, 285);

        // Reset mid-press: immediate release, command lost.
        column = 4'b0000;
        send(7, 100);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_row", row, 4'b1111);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_ka", key_active, 0);
        chk("mid_rst_busy", busy, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #2;

        column = 4'b1011;
        measure(15, 3, n_act, idx, ka0, row0);
        chk("post_rst_len", n_act, 3);
        chk("post_rst_ka", ka0, 16'h8000);
        chk("post_rst_row", row0, 4'b1110);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
